// File: rtl/mux_arbiter_8_pkg.sv
// Shared constants and state encoding for the 8-to-1 round-robin collector.
package mux_arbiter_8_pkg;

    localparam int NUM_SRC = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick_8.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick_8
    import mux_arbiter_8_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [SEL_W-1:0]     off;

    // Rotate so ptr lands at bit 0, find the lowest set bit, then add ptr back.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NUM_SRC-1:0];
        found = 1'b0;
        off   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = SEL_W'(i);
            end
        end
        idx = ptr + off;  // 3-bit add wraps modulo 8
    end

endmodule

// File: rtl/mux_arbiter_8.sv
// Round-robin 8-to-1 collector: latches one source word, tags it, holds it
// until the sink handshakes, then advances priority past the served source.
module mux_arbiter_8
    import mux_arbiter_8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       Enable,
    input  logic [NUM_SRC-1:0]         ReqIn,
    input  logic [NUM_SRC*WIDTH-1:0]   DataIn,
    output logic [NUM_SRC-1:0]         GrantOut,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [WIDTH-1:0]           OutData,
    output logic [SEL_W-1:0]           OutSel
);

    state_t             state, next_state;
    logic [SEL_W-1:0]   ptr;
    logic               found;
    logic [SEL_W-1:0]   pick_idx;
    logic [WIDTH-1:0]   pick_data;
    logic               accept;
    logic               handshake;

    rr_pick_8 u_pick (
        .req   (ReqIn),
        .ptr   (ptr),
        .found (found),
        .idx   (pick_idx)
    );

    // Select the winning source's data slice.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick_idx == SEL_W'(i))
                pick_data = DataIn[i*WIDTH +: WIDTH];
        end
    end

    // Next-state logic: accept only from IDLE, release only on the handshake.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (Enable && found) begin
                    accept     = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (OutValid && OutReady) begin
                    handshake  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Output registers, grant pulse and priority pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr      <= '0;
            OutValid <= 1'b0;
            OutData  <= '0;
            OutSel   <= '0;
            GrantOut <= '0;
        end else begin
            GrantOut <= accept ? (NUM_SRC'(1) << pick_idx) : '0;
            if (accept) begin
                OutData  <= pick_data;
                OutSel   <= pick_idx;
                OutValid <= 1'b1;
            end else if (handshake) begin
                OutValid <= 1'b0;
                ptr      <= OutSel + 1'b1;  // wraps 7 -> 0
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter_8.sv
// Scoreboard bench for mux_arbiter_8: a behavioural model predicts each
// accepted word, a negedge monitor compares the DUT against it.
module tb_mux_arbiter_8;

    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset;
    logic           Enable;
    logic [7:0]     ReqIn;
    logic [8*W-1:0] DataIn;
    logic [7:0]     GrantOut;
    logic           OutValid;
    logic           OutReady;
    logic [W-1:0]   OutData;
    logic [2:0]     OutSel;

    mux_arbiter_8 #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .Enable   (Enable),
        .ReqIn    (ReqIn),
        .DataIn   (DataIn),
        .GrantOut (GrantOut),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutSel   (OutSel)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]   sel;
        logic [W-1:0] data;
    } exp_t;

    exp_t       q[$];
    int         m_ptr = 0;
    bit         m_busy = 0;
    logic [2:0] m_sel = '0;
    logic [7:0] m_grant = '0;
    bit         m_just_reset = 0;
    bit         started = 0;
    int         vectors = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan from the pointer, hold until the sink takes the word.
    always @(posedge clock) begin
        if (reset) begin
            started      = 1;
            m_busy       = 0;
            m_ptr        = 0;
            m_grant      = '0;
            m_just_reset = 1;
            q.delete();
        end else if (started) begin
            m_grant = '0;
            if (m_busy) begin
                if (OutReady) begin
                    m_busy = 0;
                    m_ptr  = (int'(m_sel) + 1) % 8;
                end
            end else if (Enable && ReqIn != 0) begin
                for (int k = 0; k < 8; k++) begin
                    int s;
                    s = (m_ptr + k) % 8;
                    if (!m_busy && ReqIn[s]) begin
                        exp_t e;
                        e.sel  = 3'(s);
                        e.data = DataIn[s*W +: W];
                        q.push_back(e);
                        m_busy       = 1;
                        m_sel        = 3'(s);
                        m_grant[s]   = 1'b1;
                        m_just_reset = 0;
                    end
                end
            end
        end
    end

    // Monitor: compare outputs away from the active edge.
    always @(negedge clock) begin
        if (started) begin
            check("valid", 64'(OutValid), 64'(m_busy));
            check("grant", 64'(GrantOut), 64'(m_grant));
            if (m_just_reset) begin
                check("sel_after_reset", 64'(OutSel), 64'd0);
                check("data_after_reset", 64'(OutData), 64'd0);
            end
            if (OutValid) begin
                if (q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL scoreboard_empty: OutValid=1 with no expected word at %0t", $time);
                end else begin
                    check("out_sel", 64'(OutSel), 64'(q[0].sel));
                    check("out_data", 64'(OutData), 64'(q[0].data));
                    if (OutReady) void'(q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic [7:0] r, input logic e, input logic rd, input logic rs);
        @(posedge clock);
        #1;
        ReqIn    = r;
        Enable   = e;
        OutReady = rd;
        reset    = rs;
        for (int i = 0; i < 8; i++) DataIn[i*W +: W] = $urandom;
    endtask

    initial begin
        reset = 1'b1; Enable = 1'b1; ReqIn = 8'hFF; OutReady = 1'b1; DataIn = '0;

        // Reset with all requests up; first grant afterwards must be source 0.
        step(8'hFF, 1, 1, 1);
        step(8'hFF, 1, 1, 1);
        step(8'hFF, 1, 1, 0);
        step(8'h00, 1, 1, 0);
        repeat (3) step(8'h00, 1, 1, 0);

        // Single source 5 with a known word.
        step(8'h20, 1, 1, 0);
        DataIn[5*W +: W] = 32'hDEADBEEF;
        repeat (3) step(8'h00, 1, 1, 0);

        // Round-robin wrap from a fresh pointer.
        step(8'hFF, 1, 1, 1);
        repeat (32) step(8'hFF, 1, 1, 0);
        repeat (3) step(8'h00, 1, 1, 0);

        // Backpressure: inputs churn while the word is held.
        step(8'h08, 1, 0, 0);
        repeat (5) step(8'($urandom), 1'($urandom), 0, 0);
        repeat (3) step(8'h00, 1, 1, 0);

        // Pointer skip: after source 6, 0x41 must serve 0 then 6.
        step(8'h40, 1, 1, 0);
        repeat (6) step(8'h41, 1, 1, 0);
        repeat (2) step(8'h00, 1, 1, 0);

        // Enable low blocks all grants.
        repeat (10) step(8'h01, 0, 1, 0);
        step(8'h00, 1, 1, 0);

        // Reset while holding a word, then first grant is source 0 again.
        step(8'h02, 1, 0, 0);
        step(8'h00, 1, 0, 0);
        step(8'h00, 1, 0, 1);
        repeat (3) step(8'hFF, 1, 1, 0);

        // Random traffic.
        repeat (3000)
            step(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 99) == 0));

        repeat (4) step(8'h00, 1, 1, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_8.md
# mux_arbiter_8

Round-robin 8-to-1 collector with a valid/ready handshake on its output. It merges up to eight MCU peripheral request channels onto one shared sink channel, such as the register write-back or bus master port. It is the gathering counterpart of the 1-to-8 demultiplexer that fans the shared channel out to the peripherals. Each accepted word is latched, tagged with its source index and held until the sink takes it.

## Interface
Parameters:
- WIDTH, 32, data width of every input channel and of the output channel.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Enable  in  1  arbitration enable; when low, no new source is accepted.
- ReqIn  in  8  per-source request; bit i high means source i has a word on DataIn slice i.
- DataIn  in  8*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- GrantOut  out  8  one-hot, one-cycle pulse to the accepted source; the source drops or advances its request on seeing it.
- OutValid  out  1  held word available on the output.
- OutReady  in  1  sink accepts the word in any cycle where OutValid and OutReady are both high.
- OutData  out  WIDTH  held data word.
- OutSel  out  3  index of the source that produced OutData.

## Operation
- States: IDLE and HOLD.
- Round-robin pointer Ptr (3 bits) marks the highest-priority source.
- **IDLE:**
  - If Enable=1 and ReqIn≠0, select the first set ReqIn bit scanning Ptr, Ptr+1, …, Ptr+7 (mod 8).
  - In the same clock edge: register DataIn[sel] into OutData and sel into OutSel; set OutValid=1; pulse GrantOut bit sel for exactly one cycle; go to HOLD.
  - If Enable=0 or ReqIn=0, nothing changes.
- **HOLD:**
  - OutValid, OutData and OutSel are stable. ReqIn, DataIn and Enable are ignored.
  - On the OutValid&OutReady edge: OutValid←0, Ptr←OutSel+1 (wraps 7→0), go to IDLE.
  - A new grant is never issued in the handshake cycle.
- Enable dropping in HOLD does not cancel the held word.
- GrantOut is all-zero except in the single cycle after an IDLE accept.
- Reset values:
  - OutValid=0, OutData=0, OutSel=0, GrantOut=0.
  - Ptr=0, state IDLE.
- Reset in HOLD discards the held word without a handshake. The source has already seen its grant, so the word is lost by design.
- A ReqIn bit that drops before it is granted is simply not served; there is no pending memory.

## Timing
- Request to OutValid latency: 1 cycle (ReqIn sampled at edge N, OutValid high after edge N).
- GrantOut is high in the same cycle as the first OutValid cycle.
- Minimum cycle between accepts: 2 (accept edge, then handshake edge, then next accept edge at the earliest).
- Peak throughput is one word per 2 cycles with OutReady tied high.
- If OutReady is already high when OutValid rises, the handshake completes on the next edge and OutValid is high for exactly 1 cycle.
- The output side has no combinational path from ReqIn or DataIn; all outputs are registered.
- Fairness: with all 8 requests held high, grants go 0,1,2,…,7,0 and no source waits more than 8 accepts.

## Structure
- Shared package:
  - NUM_SRC=8 and SEL_W=3 constants.
  - State enum {IDLE, HOLD}.
- Natural sub-module: rr_pick_8, a combinational priority picker.
  - Inputs: 8-bit request and 3-bit Ptr.
  - Outputs: found flag and 3-bit index.
  - Implementation: rotate by Ptr, find-first-set, un-rotate.
  - Reusable by other arbiters in the MCU.
- The top module holds the FSM, the Ptr register, the output registers and the DataIn slice mux.

## Test plan
- **Reset:** hold reset 2 cycles with ReqIn=8'hFF. Require OutValid=0, GrantOut=0 and OutSel=0 throughout. After release, the first grant is source 0.
- **Single source:** ReqIn=8'h20, DataIn slice 5 = 32'hDEADBEEF, OutReady=1. Require GrantOut=8'h20 for one cycle, OutValid=1 for one cycle, OutData=32'hDEADBEEF and OutSel=5.
- **Round-robin wrap:** ReqIn=8'hFF held, OutReady=1, 16 accepts. Require OutSel sequence 0..7,0..7, with accepts every 2 cycles.
- **Backpressure:** grant source 3, then hold OutReady=0 for 5 cycles while changing DataIn and ReqIn. Require OutData/OutSel frozen, no further GrantOut, and OutValid high until the handshake.
- **Ptr skip:** after granting source 6, set ReqIn=8'h41. Require the next grant to be source 0 (the scan order is 7, 0), then source 6.
- **Enable / reset mid-HOLD:**
  - Enable=0 with ReqIn=8'h01: require no grant for 10 cycles.
  - Assert reset while in HOLD: require OutValid=0 on the next edge and Ptr=0.
